// File: rtl/cla_segment.sv
// Purpose : SEG-bit carry-lookahead adder slice built from 4-bit CLA groups plus a group-level lookahead.
// Latency : purely combinational, zero cycles.
// Backpressure: none; the enclosing pipeline decides when results are captured.
//
// Ports: a, b (SEG)  operand slices (b already inverted by the caller for subtraction)
//        ci          carry into bit 0 of the slice
//        sum (SEG)   slice sum
//        co          carry out of the top bit of the slice
//        p_seg       slice propagate (AND of every bitwise a^b)
//        g_seg       slice generate (carry out assuming ci = 0)
module cla_segment #(
    parameter int SEG = 16
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           ci,
    output logic [SEG-1:0] sum,
    output logic           co,
    output logic           p_seg,
    output logic           g_seg
);

    localparam int NG = SEG / 4;

    logic [SEG-1:0] p;
    logic [SEG-1:0] g;
    logic [SEG-1:0] c;
    logic [NG-1:0]  grp_p;
    logic [NG-1:0]  grp_g;
    logic [NG:0]    grp_c;
    logic [SEG-1:0] grp_p_ext;
    logic [SEG-1:0] grp_g_ext;

    // Sum-of-products carry into position lo+n, given generate/propagate of
    // positions lo .. lo+n-1 and the carry into position lo. Every term is a
    // flat AND, so each carry is two logic levels deep rather than a ripple.
    function automatic logic carry_into(
        input logic [SEG-1:0] gv,
        input logic [SEG-1:0] pv,
        input logic           cin,
        input int             lo,
        input int             n
    );
        logic acc;
        logic term;
        acc = cin;
        for (int m = 0; m < SEG; m++) begin
            if (m >= lo && m < lo + n) acc = acc & pv[m];
        end
        for (int i = 0; i < SEG; i++) begin
            if (i >= lo && i < lo + n) begin
                term = gv[i];
                for (int m = 0; m < SEG; m++) begin
                    if (m > i && m < lo + n) term = term & pv[m];
                end
                acc = acc | term;
            end
        end
        return acc;
    endfunction

    always_comb begin
        p         = a ^ b;
        g         = a & b;
        grp_p     = '0;
        grp_g     = '0;
        grp_p_ext = '0;
        grp_g_ext = '0;
        grp_c     = '0;
        c         = '0;

        // First level: 4-bit group propagate / generate.
        for (int j = 0; j < NG; j++) begin
            grp_p[j] = &p[4*j +: 4];
            grp_g[j] = carry_into(g, p, 1'b0, 4*j, 4);
        end
        grp_p_ext[NG-1:0] = grp_p;
        grp_g_ext[NG-1:0] = grp_g;

        // Second level: carry into each group straight from ci and group terms.
        grp_c[0] = ci;
        for (int j = 1; j <= NG; j++) begin
            grp_c[j] = carry_into(grp_g_ext, grp_p_ext, ci, 0, j);
        end

        // Bit carries inside each group, seeded by that group's lookahead carry.
        for (int j = 0; j < NG; j++) begin
            for (int k = 0; k < 4; k++) begin
                c[4*j + k] = carry_into(g, p, grp_c[j], 4*j, k);
            end
        end
    end

    assign sum   = p ^ c;
    assign co    = grp_c[NG];
    assign p_seg = &grp_p;
    assign g_seg = carry_into(grp_g_ext, grp_p_ext, 1'b0, 0, NG);

endmodule

// File: rtl/pipelined_cla_adder.sv
// Purpose : WIDTH-bit add/subtract split into NSTG = WIDTH/SEG pipelined CLA segments.
// Latency : NSTG cycles from input handshake to out_valid; one result per cycle when not stalled.
// Backpressure: whole pipe freezes while out_valid && !out_ready; in_ready drops combinationally.
//
// Ports: clk, rst_n        rising-edge clock, async active-low reset
//        A, B, Ci, sub     operands, carry-in (ignored when sub=1), subtract select
//        in_valid/in_ready input handshake
//        S, Co, ovf        sum, carry out of the MSB, two's-complement overflow
//        PG, GG            whole-word group propagate / generate (independent of carry-in)
//        out_valid/out_ready output handshake
module pipelined_cla_adder #(
    parameter int WIDTH = 32,
    parameter int SEG   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Ci,
    input  logic             sub,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] S,
    output logic             Co,
    output logic             ovf,
    output logic             PG,
    output logic             GG,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int NSTG = WIDTH / SEG;

    if ((WIDTH % SEG) != 0 || (SEG % 4) != 0 || SEG < 4 || WIDTH < 8) begin : g_param_check
        $error("pipelined_cla_adder: WIDTH must be a multiple of SEG (>= 8) and SEG a multiple of 4");
    end

    // A single advance enable for every stage keeps the pipe in lock-step:
    // it moves whenever the output slot is empty or is being drained.
    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < NSTG; k++) begin : stg
        // Operand bits still to be added when this stage runs (its own
        // segment in the low SEG bits, the untouched upper bits above).
        localparam int IW = WIDTH - k*SEG;

        logic [IW-1:0]         a_in;
        logic [IW-1:0]         b_in;
        logic                  c_in;
        logic                  pg_in;
        logic                  gg_in;
        logic                  v_in;
        logic [SEG-1:0]        sum_seg;
        logic                  co_seg;
        logic                  p_seg;
        logic                  g_seg;
        logic [(k+1)*SEG-1:0]  s_nxt;
        logic [(k+1)*SEG-1:0]  s_q;
        logic                  vld_q;
        logic                  c_q;
        logic                  pg_q;
        logic                  gg_q;

        if (k == 0) begin : head
            // Subtraction is A + ~B + 1, so Ci is overridden when sub=1.
            assign a_in  = A;
            assign b_in  = sub ? ~B : B;
            assign c_in  = sub | Ci;
            assign pg_in = 1'b1;
            assign gg_in = 1'b0;
            assign v_in  = in_valid;
            assign s_nxt = sum_seg;
        end else begin : body
            assign a_in  = stg[k-1].fwd.a_q;
            assign b_in  = stg[k-1].fwd.b_q;
            assign c_in  = stg[k-1].c_q;
            assign pg_in = stg[k-1].pg_q;
            assign gg_in = stg[k-1].gg_q;
            assign v_in  = stg[k-1].vld_q;
            assign s_nxt = {sum_seg, stg[k-1].s_q};
        end

        cla_segment #(
            .SEG (SEG)
        ) u_seg (
            .a     (a_in[SEG-1:0]),
            .b     (b_in[SEG-1:0]),
            .ci    (c_in),
            .sum   (sum_seg),
            .co    (co_seg),
            .p_seg (p_seg),
            .g_seg (g_seg)
        );

        // PG/GG are folded in from low to high segments; GG is seeded with 0
        // so it never sees the real carry-in.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= 1'b0;
                s_q   <= '0;
                c_q   <= 1'b0;
                pg_q  <= 1'b0;
                gg_q  <= 1'b0;
            end else if (adv) begin
                vld_q <= v_in;
                s_q   <= s_nxt;
                c_q   <= co_seg;
                pg_q  <= pg_in & p_seg;
                gg_q  <= g_seg | (p_seg & gg_in);
            end
        end

        if (k < NSTG-1) begin : fwd
            logic [IW-SEG-1:0] a_q;
            logic [IW-SEG-1:0] b_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= a_in[IW-1:SEG];
                    b_q <= b_in[IW-1:SEG];
                end
            end
        end else begin : tail
            logic ovf_q;

            // Overflow: operands agree in sign but the sum's sign differs.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (adv) begin
                    ovf_q <= (a_in[SEG-1] == b_in[SEG-1]) && (sum_seg[SEG-1] != a_in[SEG-1]);
                end
            end

            assign S         = s_q;
            assign Co        = c_q;
            assign ovf       = ovf_q;
            assign PG        = pg_q;
            assign GG        = gg_q;
            assign out_valid = vld_q;
        end
    end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
module tb_pipelined_cla_adder;

    localparam int W   = 32;
    localparam int LAT = 2;

    logic          clk;
    logic          rst_n;
    logic [W-1:0]  A;
    logic [W-1:0]  B;
    logic          Ci;
    logic          sub;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  S;
    logic          Co;
    logic          ovf;
    logic          PG;
    logic          GG;
    logic          out_valid;
    logic          out_ready;

    pipelined_cla_adder #(.WIDTH(W), .SEG(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .A         (A),
        .B         (B),
        .Ci        (Ci),
        .sub       (sub),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .S         (S),
        .Co        (Co),
        .ovf       (ovf),
        .PG        (PG),
        .GG        (GG),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    typedef struct {
        logic [W-1:0] s;
        logic         co;
        logic         ovf;
        logic         pg;
        logic         gg;
        int           acc_cyc;
        bit           nostall;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   ready_mode = 1;  // 0: never ready, 1: always ready, 2: random
    bit   front_seen = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: plain wide arithmetic on the effective operands.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci, input logic sb_op);
        exp_t         e;
        logic [W-1:0] bp;
        logic         c0;
        logic [W:0]   full;
        logic [W:0]   nocin;
        bp    = sb_op ? ~b : b;
        c0    = sb_op ? 1'b1 : ci;
        full  = {1'b0, a} + {1'b0, bp} + {{W{1'b0}}, c0};
        nocin = {1'b0, a} + {1'b0, bp};
        e.s       = full[W-1:0];
        e.co      = full[W];
        e.ovf     = (a[W-1] == bp[W-1]) && (e.s[W-1] != a[W-1]);
        e.pg      = ((a ^ bp) == {W{1'b1}});
        e.gg      = nocin[W];
        e.acc_cyc = 0;
        e.nostall = 0;
        return e;
    endfunction

    task automatic drive_ready();
        case (ready_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            drive_ready();
            in_valid = 1'b0;
            @(negedge clk);
        end
    endtask

    // Presents one operation until accepted; the expected result is queued
    // at the negedge just before the accepting clock edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci, input logic sb_op);
        exp_t e;
        int   tries;
        bit   done;
        tries = 0;
        done  = 0;
        while (!done) begin
            @(posedge clk);
            #1;
            drive_ready();
            in_valid = 1'b1;
            A        = a;
            B        = b;
            Ci       = ci;
            sub      = sb_op;
            @(negedge clk);
            if (in_ready) begin
                e         = model(a, b, ci, sb_op);
                e.acc_cyc = cyc;
                e.nostall = (ready_mode == 1);
                sb.push_back(e);
                done = 1;
            end else if (++tries > 200) begin
                chk(1'b0, "issue_timeout", 64'(tries), 64'd200);
                done = 1;
            end
        end
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'h0000_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Monitor: compares whatever the DUT presents against the queue front,
    // every cycle it is visible, and pops on an output transfer.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk(in_ready == (!out_valid || out_ready), "in_ready_rule", 64'(in_ready), 64'(!out_valid || out_ready));
                if (out_valid) begin
                    chk(sb.size() != 0, "unexpected_output", 64'(S), 64'd0);
                    if (sb.size() != 0) begin
                        e = sb[0];
                        chk(S == e.s,     "S",   64'(S),   64'(e.s));
                        chk(Co == e.co,   "Co",  64'(Co),  64'(e.co));
                        chk(ovf == e.ovf, "ovf", 64'(ovf), 64'(e.ovf));
                        chk(PG == e.pg,   "PG",  64'(PG),  64'(e.pg));
                        chk(GG == e.gg,   "GG",  64'(GG),  64'(e.gg));
                        if (!front_seen) begin
                            front_seen = 1;
                            if (e.nostall)
                                chk(cyc - e.acc_cyc == LAT, "latency", 64'(cyc - e.acc_cyc), 64'(LAT));
                            else
                                chk(cyc - e.acc_cyc >= LAT, "latency_min", 64'(cyc - e.acc_cyc), 64'(LAT));
                        end
                        if (out_ready) begin
                            void'(sb.pop_front());
                            front_seen = 0;
                        end
                    end
                end
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        A         = '0;
        B         = '0;
        Ci        = 1'b0;
        sub       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;

        // Reset state.
        #12;
        chk(out_valid == 1'b0, "rst_out_valid", 64'(out_valid), 64'd0);
        chk(S == '0, "rst_S", 64'(S), 64'd0);
        chk({Co, ovf, PG, GG} == 4'b0, "rst_flags", 64'({Co, ovf, PG, GG}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk(in_ready == 1'b1, "post_rst_in_ready", 64'(in_ready), 64'd1);

        // Directed boundary cases.
        ready_mode = 1;
        issue(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        issue(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
        issue(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
        issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 1'b1);
        issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        idle(4);

        // Stall: fill the pipe with the output blocked, then release.
        ready_mode = 0;
        idle(1);
        issue($urandom, $urandom, 1'b0, 1'b0);
        issue($urandom, $urandom, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            idle(1);
            chk(in_ready == 1'b0, "stall_in_ready", 64'(in_ready), 64'd0);
            chk(out_valid == 1'b1, "stall_out_valid", 64'(out_valid), 64'd1);
        end
        ready_mode = 1;
        issue($urandom, $urandom, 1'b1, 1'b0);
        idle(6);
        chk(sb.size() == 0, "stall_drain", 64'(sb.size()), 64'd0);

        // Randomised traffic with random backpressure and input gaps.
        ready_mode = 2;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            issue(pick_operand(), pick_operand(), 1'($urandom), 1'($urandom));
        end
        ready_mode = 1;
        idle(10);
        chk(sb.size() == 0, "random_drain", 64'(sb.size()), 64'd0);

        // Reset in the middle of traffic: outputs clear at once, nothing stale later.
        issue($urandom, $urandom, 1'b0, 1'b0);
        issue($urandom, $urandom, 1'b1, 1'b0);
        issue($urandom, $urandom, 1'b0, 1'b1);
        idle(1);
        #2;
        chk(out_valid == 1'b1, "pre_rst_busy", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk(out_valid == 1'b0, "midrst_out_valid", 64'(out_valid), 64'd0);
        chk(S == '0, "midrst_S", 64'(S), 64'd0);
        chk({Co, ovf, PG, GG} == 4'b0, "midrst_flags", 64'({Co, ovf, PG, GG}), 64'd0);
        sb.delete();
        front_seen = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk(in_ready == 1'b1, "rel_in_ready", 64'(in_ready), 64'd1);
        chk(out_valid == 1'b0, "rel_out_valid", 64'(out_valid), 64'd0);
        idle(6);
        issue(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0);
        idle(5);
        chk(sb.size() == 0, "final_drain", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pipelined_cla_adder.md
PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

Interface
REQ-001 Parameter WIDTH, default 32: operand width; legal values are multiples of SEG, minimum 8.
REQ-002 Parameter SEG, default 16: bits per pipeline segment; legal values are multiples of 4.
REQ-003 Derived constant NSTG = WIDTH/SEG: number of pipeline stages, which equals the latency.
REQ-004 Ports: clk (in, 1): single clock, rising edge; rst_n (in, 1): reset, asynchronous, active-low.
REQ-005 Ports: A (in, WIDTH), B (in, WIDTH): operands; Ci (in, 1): carry-in; sub (in, 1): 1 selects A-B.
REQ-006 Ports: in_valid (in, 1) and in_ready (out, 1): input handshake.
REQ-007 Ports: S (out, WIDTH): sum; Co (out, 1): carry-out; ovf (out, 1): two's-complement overflow.
REQ-008 Ports: PG (out, 1), GG (out, 1): whole-word group propagate and group generate.
REQ-009 Ports: out_valid (out, 1) and out_ready (in, 1): output handshake.

Function
REQ-010 Transfer on each handshake channel only on a rising clk edge with valid=1 and ready=1.
REQ-011 Operand B' = sub ? ~B : B; effective carry-in c0 = sub ? 1 : Ci, so Ci is ignored when sub=1.
REQ-012 Stage k (0..NSTG-1) computes bits [k*SEG +: SEG] with 4-bit CLA groups and a second-level lookahead across the groups.
REQ-013 Stage k takes its carry-in from the stage k-1 register; stage 0 takes c0.
REQ-014 Operand bits above the current segment are carried forward in the stage registers, unmodified.
REQ-015 Latency is exactly NSTG cycles from input handshake to out_valid=1; with no stalls, throughput is one result per cycle.
REQ-016 Global advance: adv = !out_valid || out_ready; all stage registers load only when adv=1.
REQ-017 in_ready = adv, combinationally.
REQ-018 Each stage holds a valid bit; a bubble (in_valid=0 while adv=1) propagates as valid=0.
REQ-019 While out_valid=1 and out_ready=0: S, Co, ovf, PG and GG are held stable and in_ready=0.
REQ-020 Co = carry out of bit WIDTH-1.
REQ-021 ovf = (A'[WIDTH-1] == B'[WIDTH-1]) && (S[WIDTH-1] != A'[WIDTH-1]), where A' = A.
REQ-022 PG = AND of all bitwise (A' xor B'), i.e. AND of all bitwise propagate terms.
REQ-023 GG = carry-out that would result with c0=0; both PG and GG are independent of c0.
REQ-024 All arithmetic is modulo 2^WIDTH; there is no saturation.
REQ-025 Outputs S/Co/ovf/PG/GG are registered, with no combinational path from A, B, Ci or sub.
REQ-026 Simultaneous output drain and input accept in the same cycle is legal and loses no data.

Reset
REQ-027 rst_n=0 asynchronously clears all stage valid bits, so out_valid=0 immediately.
REQ-028 During reset, S=0, Co=0, ovf=0, PG=0 and GG=0.
REQ-029 After reset deasserts, in_ready=1.
REQ-030 Reset asserted mid-operation discards all in-flight operations; none emerge after reset.

Structure
REQ-031 One sub-module, cla_segment: SEG-bit combinational CLA with outputs sum, carry-out, segment P and segment G; it is instantiated NSTG times.
REQ-032 No shared package is used; WIDTH, SEG and NSTG are module parameters or localparams only.
REQ-033 An elaboration-time check flags WIDTH % SEG != 0 or SEG % 4 != 0.

Verification (WIDTH=32, SEG=16, so latency 2)
REQ-034 Reset: assert rst_n=0 mid-stream -> out_valid=0 and S=0 at once; after release, in_ready=1 and no stale outputs appear.
REQ-035 Carry crossing a stage boundary: A=0x0000FFFF, B=0x00000001, Ci=0, sub=0 -> 2 cycles later S=0x00010000, Co=0, ovf=0, PG=0, GG=0.
REQ-036 Full propagate: A=0xFFFFFFFF, B=0, Ci=1 -> S=0x00000000, Co=1, PG=1, GG=0.
REQ-037 Subtract overflow: A=0x80000000, B=0x00000001, sub=1, Ci=0 -> S=0x7FFFFFFF, Co=1, ovf=1.
REQ-038 Stall: issue 3 back-to-back ops with out_ready=0 -> results hold and in_ready=0 after the pipe fills; raise out_ready -> results appear in order, none lost or duplicated.
REQ-039 Random: 10k random A/B/Ci/sub with random out_ready -> every result matches the reference model computed as (A + B' + c0) with carry and overflow.
